// File: rtl/mem_dump_reader.sv
// mem_dump_reader: walks data memory after halt and streams each word LSB-first to the debug UART TX
module mem_dump_reader #(
  parameter int len_data  = 32,
  parameter int addr_bits = 8,
  parameter int num_words = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 mem_rd,
  output logic [addr_bits-1:0] mem_addr,
  input  logic [len_data-1:0]  mem_data,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_done,
  output logic                 busy,
  output logic                 done
);
  typedef enum logic [2:0] {IDLE, READ, LATCH, SEND, WAIT_TX, DONE} state_e;
  localparam logic [addr_bits-1:0] LastAddr = addr_bits'(num_words - 1);
  state_e                state_q;
  logic [1:0]            byte_idx_q;
  logic [len_data-1:0]   buf_q;
  logic [addr_bits-1:0]  addr_q;
  logic [7:0]            tx_data_q;
  logic                  mem_rd_q, tx_start_q, busy_q, done_q;
  // outputs are set on entry to the state that owns them, so they are valid for exactly that state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      byte_idx_q <= '0;
      buf_q      <= '0;
      addr_q     <= '0;
      tx_data_q  <= '0;
      mem_rd_q   <= 1'b0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      mem_rd_q   <= 1'b0;
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q  <= READ;
          addr_q   <= '0;
          mem_rd_q <= 1'b1;
          busy_q   <= 1'b1;
        end
        READ: state_q <= LATCH;
        LATCH: begin
          buf_q      <= mem_data;
          byte_idx_q <= '0;
          tx_data_q  <= mem_data[7:0];
          tx_start_q <= 1'b1;
          state_q    <= SEND;
        end
        SEND: state_q <= WAIT_TX;
        WAIT_TX: if (tx_done) begin
          buf_q <= buf_q >> 8;
          if (byte_idx_q != 2'd3) begin
            byte_idx_q <= byte_idx_q + 2'd1;
            tx_data_q  <= buf_q[15:8];
            tx_start_q <= 1'b1;
            state_q    <= SEND;
          end else if (addr_q == LastAddr) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            addr_q   <= addr_q + addr_bits'(1);
            mem_rd_q <= 1'b1;
            state_q  <= READ;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign mem_rd   = mem_rd_q;
  assign mem_addr = addr_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign busy     = busy_q;
  assign done     = done_q;
endmodule

// File: tb/tb_mem_dump_reader.sv
// tb_mem_dump_reader: randomized scoreboard bench with memory and UART TX models
module tb_mem_dump_reader;
  localparam int NW = 4;
  localparam int AB = 8;
  logic          clk = 1'b0, reset = 1'b1, start = 1'b0, tx_done = 1'b0;
  logic          mem_rd, tx_start, busy, done;
  logic [AB-1:0] mem_addr;
  logic [31:0]   mem_data;
  logic [7:0]    tx_data;
  logic [31:0]   mem [256];
  logic [8:0]    exp_q[$];
  int            addr_q[$];
  int            n_chk = 0, n_fail = 0, tx_cnt = 0, done_cnt = 0;
  int            max_delay = 1, cnt = 0;
  bit            rnd_dly = 0, spur_en = 0, prev_done = 0;
  logic          r;
  logic [8:0]    e;
  logic [7:0]    last_tx = 8'h00;
  int            a;

  always #5 clk = ~clk;

  mem_dump_reader #(.len_data(32), .addr_bits(AB), .num_words(NW)) dut (
    .clk(clk), .reset(reset), .start(start), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_data(mem_data), .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
    .busy(busy), .done(done)
  );

  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event occurred with nothing expected", nm);
  endtask

  // UART model: tx_done `delay` cycles after tx_start; optional spurious pulses outside WAIT_TX
  initial forever begin
    @(posedge clk);
    #1;
    if (tx_start) begin
      cnt = rnd_dly ? int'($urandom_range(1, max_delay)) : max_delay;
      tx_done = spur_en && ($urandom_range(0, 1) == 1);
    end else if (cnt > 0) begin
      cnt--;
      tx_done = (cnt == 0);
    end else
      tx_done = spur_en && (mem_rd || done || !busy) && ($urandom_range(0, 1) == 1);
  end

  initial forever begin
    @(posedge clk);
    r = reset;
    #2;
    if (r) begin
      chk("reset_outputs", {12'h0, mem_rd, mem_addr, tx_data, tx_start, busy, done}, 32'h0);
      last_tx = 8'h00;
      prev_done = 0;
    end else begin
      if (prev_done) chk("idle_after_done", busy, 0);
      prev_done = done;
      if (tx_start) begin
        tx_cnt++;
        if (exp_q.size() == 0) flag("tx_start_unexpected");
        else begin
          e = exp_q.pop_front();
          chk("tx_byte", {23'h0, 1'b0, tx_data}, {23'h0, e});
        end
        last_tx = tx_data;
      end else chk("tx_data_hold", tx_data, last_tx);
      if (mem_rd) begin
        if (addr_q.size() == 0) flag("mem_rd_unexpected");
        else begin
          a = addr_q.pop_front();
          chk("mem_addr", mem_addr, a);
        end
      end
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) flag("done_unexpected");
        else begin
          e = exp_q.pop_front();
          chk("done_after_last_byte", {23'h0, done, 8'h00}, {23'h0, e});
        end
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) @(posedge clk);
    chk("idle_before_start", busy, 0);
  endtask

  task automatic push_dump();
    for (int w = 0; w < NW; w++) begin
      addr_q.push_back(w);
      for (int b = 0; b < 4; b++) exp_q.push_back({1'b0, mem[w][8*b +: 8]});
    end
    exp_q.push_back(9'h100);
  endtask

  task automatic run_dump(input int d, input bit rnd, input bit spur, input bit mid);
    int cyc, first;
    bit got;
    max_delay = d;
    rnd_dly = rnd;
    spur_en = spur;
    wait_idle();
    push_dump();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0; #2;
    cyc = 1;
    first = 0;
    got = 0;
    chk("read_after_start", mem_rd, 1);
    while (cyc < 4000 && !got) begin
      chk("busy_in_dump", busy, 1);
      if (tx_start && first == 0) first = cyc;
      if (done) got = 1;
      else begin
        @(posedge clk); #1 start = mid && (cyc == 4); #2;
        cyc++;
      end
    end
    chk("dump_completes", got, 1);
    chk("first_tx_cycle", first, 3);
    if (!rnd) chk("done_cycle", cyc, 1 + NW * (2 + 4 * (1 + d)));
    @(posedge clk); #3;
    chk("queue_drained", exp_q.size() + addr_q.size(), 0);
  endtask

  initial begin
    int base, d0, c, c_done, nd;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h11223344;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    run_dump(1, 0, 0, 0);
    for (int i = 0; i < NW; i++) mem[i] = 32'hA0A0A0A0 + i;
    run_dump(7, 0, 0, 0);
    for (int i = 0; i < NW; i++) mem[i] = $urandom;
    run_dump(3, 0, 1, 1);
    run_dump(6, 1, 1, 0);
    // abort during WAIT_TX of word 2, byte 1 (the 10th byte)
    mem[0] = 32'h11223344;
    max_delay = 4;
    rnd_dly = 0;
    spur_en = 0;
    wait_idle();
    push_dump();
    base = tx_cnt;
    d0 = done_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 2000 && tx_cnt != base + 10; i++) begin
      @(posedge clk); #3;
    end
    chk("reached_word2_byte1", tx_cnt - base, 10);
    @(posedge clk); #1 reset = 1'b1;
    exp_q.delete();
    addr_q.delete();
    @(posedge clk); #1 reset = 1'b0;
    repeat (12) @(posedge clk);
    #3 chk("no_done_after_reset", done_cnt, d0);
    run_dump(2, 1, 1, 0);
    // start held high across two dumps
    max_delay = 2;
    rnd_dly = 0;
    wait_idle();
    push_dump();
    push_dump();
    d0 = done_cnt;
    c = 0;
    c_done = 0;
    nd = 0;
    @(posedge clk); #1 start = 1'b1;
    while (c < 4000 && nd < 2) begin
      @(posedge clk); #3;
      c++;
      if (done) begin
        nd++;
        if (nd == 1) c_done = c;
        else start = 1'b0;
      end
      if (nd == 1 && c == c_done + 2) begin
        chk("restart_rd", mem_rd, 1);
        chk("restart_addr", mem_addr, 0);
      end
    end
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3 chk("done_pulses", done_cnt - d0, 2);
    chk("held_queue_drained", exp_q.size() + addr_q.size(), 0);
    chk("idle_at_end", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
